reg_file_mp: RTL
================

Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the IITB-RISC-23 pipeline.
- Generalises the single-write, 2-read file to NUM_RD read ports and NUM_WR write ports, with write priority and same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard:
  - ID stage sets a register busy when it issues a producer.
  - WB clears the busy bit when the producer writes back.
  - Hazard logic uses the busy bit to stall consumers.
- A registered write-conflict flag is provided for debug.

Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 8, number of architectural registers (need not be a power of 2)
- ADDR_W, $clog2(NUM_REGS), register address width
- NUM_RD, 3, number of read ports
- NUM_WR, 2, number of write ports; a higher index has higher priority
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- raddr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  packed read data, combinational
- rbusy  out  NUM_RD  per read port: addressed register still awaiting writeback
- we  in  NUM_WR  per-port write enable
- waddr  in  NUM_WR*ADDR_W  packed write addresses
- wdata  in  NUM_WR*DATA_W  packed write data
- issue_valid  in  1  mark issue_addr busy at this edge
- issue_addr  in  ADDR_W  destination register of the issued producer
- flush  in  1  clear all busy bits (pipeline flush)
- busy_vec  out  NUM_REGS  current scoreboard state, registered
- wr_conflict  out  1  registered pulse: two or more enabled write ports targeted the same register in the previous cycle

Behaviour:
- Reset (asynchronous, rst_n=0, any time including mid-operation):
  - all registers = 0; busy_vec = 0; wr_conflict = 0.
  - Reads during reset return 0 and rbusy = 0. Bypass is inactive while rst_n=0.
- Write (posedge):
  - For each register, the highest-index port j with we[j] and waddr[j] matching that register writes wdata[j].
  - Lower-index ports to the same address are discarded.
  - Different addresses on different ports all commit in the same cycle.
- Read (combinational, zero latency):
  - rdata[i] = regs[raddr[i]].
  - If BYPASS=1 and some enabled write port targets raddr[i] this cycle, rdata[i] = wdata of the highest-index such port (same priority as commit).
- Address range:
  - An address >= NUM_REGS reads 0 with rbusy 0.
  - Writes and issues to such an address are ignored; they do not count toward wr_conflict.
- Scoreboard next state, per register r, in priority order (later rule overrides earlier):
  1. flush=1 clears r.
  2. Any enabled write to r clears r.
  3. issue_valid=1 with issue_addr==r sets r.
  - So a same-cycle issue beats both writeback and flush: the new producer owns r.
- rbusy[i] = busy_vec[raddr[i]] AND NOT (any enabled write to raddr[i] this cycle).
  - The second term applies only when BYPASS=1.
  - When BYPASS=0, rbusy[i] = busy_vec[raddr[i]].
  - A same-cycle issue does not affect rbusy until the next cycle.
- wr_conflict:
  - Registered 1 at the edge after any cycle with two or more enabled ports at the same valid address; 0 otherwise.
  - It is a single-cycle pulse per offending cycle.
- No register is hardwired. All NUM_REGS registers are writable, including R0/PC.

Test Plan:
- Reset mid-stream: write R3=0x1234 and issue R5, then pull rst_n low between edges -> immediately rdata=0 for all ports and busy_vec=0; after release, R3 reads 0x0000.
- Write priority: we=2'b11, waddr0=waddr1=4, wdata0=0xAAAA, wdata1=0x5555 -> same cycle rdata(raddr=4)=0x5555 via bypass; next cycle R4=0x5555; wr_conflict=1 for exactly one cycle.
- Bypass vs stored (BYPASS=1): R2=0x0001 stored, then in one cycle we0 R2=0x00FF with raddr0=raddr1=2 -> both ports read 0x00FF; next cycle 0x00FF. With BYPASS=0, the same stimulus reads 0x0001, then 0x00FF.
- Scoreboard:
  - Issue R6 -> busy_vec[6]=1 next cycle, rbusy=1 on a reader of R6.
  - Writeback R6=0x0042 -> that same cycle rbusy=0 and rdata=0x0042; next cycle busy_vec[6]=0.
- Simultaneous events:
  - With R1 busy, in one cycle apply writeback R1, issue_valid on R1 and flush -> busy_vec[1]=1, all other busy bits 0.
  - Next cycle, write R1 alone -> busy_vec[1]=0.
- NUM_REGS=6 build: write/issue to address 7 -> no state change, no wr_conflict; reading address 7 returns 0 with rbusy 0.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port register file with priority writes, same-cycle write-to-read bypass
// and a per-register busy scoreboard for hazard detection.
module reg_file_mp #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 3,
  parameter int NUM_WR   = 2,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic                     wr_conflict
);

  logic [DATA_W-1:0]   regs   [NUM_REGS];
  logic [DATA_W-1:0]   wr_val [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] busy_next;
  logic                conflict_next;
  logic [ADDR_W-1:0]   rd_addr [NUM_RD];

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_addr
    assign rd_addr[g] = raddr[g*ADDR_W +: ADDR_W];
  end

  // Per-register write decode; scanning upward lets the highest-index port win.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && (waddr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wdata[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Out-of-range addresses never collide, since they write nothing.
  always_comb begin
    conflict_next = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      for (int k = j + 1; k < NUM_WR; k++) begin
        if (we[j] && we[k] &&
            (waddr[j*ADDR_W +: ADDR_W] == waddr[k*ADDR_W +: ADDR_W]) &&
            (int'(waddr[j*ADDR_W +: ADDR_W]) < NUM_REGS))
          conflict_next = 1'b1;
      end
    end
  end

  // Issue beats writeback beats flush: a fresh producer must own the register.
  always_comb begin
    busy_next = busy_vec;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (flush)
        busy_next[r] = 1'b0;
      if (wr_hit[r])
        busy_next[r] = 1'b0;
      if (issue_valid && (issue_addr == ADDR_W'(r)))
        busy_next[r] = 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rst_n && (int'(rd_addr[i]) < NUM_REGS)) begin
        rdata[i*DATA_W +: DATA_W] = regs[rd_addr[i]];
        rbusy[i]                  = busy_vec[rd_addr[i]];
        if (BYPASS && wr_hit[rd_addr[i]]) begin
          rdata[i*DATA_W +: DATA_W] = wr_val[rd_addr[i]];
          rbusy[i]                  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs[r] <= '0;
      busy_vec    <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        if (wr_hit[r])
          regs[r] <= wr_val[r];
      busy_vec    <= busy_next;
      wr_conflict <= conflict_next;
    end
  end

endmodule
